// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller: feeds an external 4-bit ripple adder one nibble per cycle.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                   out_ovf
`endif
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, next_state;
    logic [W-1:0]    a_reg, b_reg;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic            accept;
    logic [IDXW+1:0] bit_base;

    assign accept   = (state == IDLE) && in_valid;
    assign bit_base = {idx, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                add_a   = a_reg[bit_base +: 4];
                add_b   = b_reg[bit_base +: 4];
                add_cin = carry;
                if (idx == LAST) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Results are only written in RUN, so they hold steady through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            idx   <= '0;
            carry <= in_cin;
        end else if (state == RUN) begin
            out_sum[bit_base +: 4] <= add_s;
            carry                  <= add_cout;
            idx                    <= idx + 1'b1;
            if (idx == LAST) out_cout <= add_cout;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    // The final nibble's sum bit 3 is the result sign bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_ovf <= 1'b0;
        else if (state == RUN && idx == LAST)
            out_ovf <= (a_reg[W-1] == b_reg[W-1]) && (add_s[3] != a_reg[W-1]);
    end
`endif

endmodule
